bash_f_round_ctrl: RTL and testbench
====================================

// Module: bash_f_round_ctrl
// PURPOSE
//   Round sequencer for the bash-f permutation. Owns the round-constant register and the
//   round counter, and steps the constant through bash_f_c once per accepted round.
//   Presents (round index, C_i) to the bash-f round datapath with a valid/ready handshake,
//   then signals completion. Sits directly upstream of bash_f_c (feeds c_i, captures c_o)
//   and beside the round datapath (consumes rc_o, returns round_rdy_i).
// PARAMETERS
//   ROUNDS  BASH_F_ROUNDS (24)     number of rounds per permutation; legal range 2..32
//   CNT_W   $clog2(ROUNDS) (5)     round counter width; derived, not overridden
// PORTS
//   clk_i        in   1      clock, all flops rising edge
//   rst_i        in   1      asynchronous reset, active-high
//   start_i      in   1      request a permutation; accepted when start_i & ready_o
//   ready_o      out  1      controller can accept start (IDLE or DONE)
//   busy_o       out  1      high in RUN
//   round_vld_o  out  1      rc_o/round_idx_o valid for the datapath (RUN only)
//   round_rdy_i  in   1      datapath consumed the current round this cycle
//   round_idx_o  out  CNT_W  current round number, 0..ROUNDS-1
//   rc_o         out  SLEN   current round constant C_(idx+1), bash_f_c byte order
//   last_o       out  1      round_vld_o & (round_idx_o == ROUNDS-1)
//   done_o       out  1      one-cycle pulse: permutation complete
//   abort_i      in   1      only with BASH_F_CTRL_ABORT_EN; cancel current permutation
// BEHAVIOUR
//   Reset (async, rst_i=1): state=IDLE, rc_q=BASH_F_C1, cnt_q=0; ready_o=1, busy_o=0,
//     round_vld_o=0, done_o=0, last_o=0, round_idx_o=0, rc_o=BASH_F_C1.
//   FSM IDLE -> RUN on start; RUN -> DONE when round_rdy_i & last; DONE -> IDLE unconditional,
//     or DONE -> RUN when start_i in DONE (back-to-back, no bubble beyond DONE cycle).
//   Start accept (IDLE/DONE): rc_q<=BASH_F_C1, cnt_q<=0, next cycle RUN with round_vld_o=1.
//   RUN: round_vld_o=1; rc_o=rc_q, round_idx_o=cnt_q held stable until round_rdy_i=1.
//   Round accept (round_vld_o & round_rdy_i): rc_q<=bash_f_c(rc_q), cnt_q<=cnt_q+1; new
//     values visible next cycle (0-cycle handshake latency, 1 round per cycle at full rate).
//   Last accept: cnt_q, rc_q cleared to 0/BASH_F_C1; state DONE; done_o=1 for exactly that cycle.
//   Minimum latency start->done_o: ROUNDS+1 cycles with round_rdy_i tied high.
//   start_i in RUN: ignored (ready_o=0); no effect on counter or constant.
//   round_rdy_i outside RUN: ignored. cnt_q never wraps past ROUNDS-1.
//   rst_i asserted mid-RUN: immediate return to reset values; no done_o.
//   rc_o is a registered output (rc_q); bash_f_c sits in the next-state path only.
// CONFIGURATION
//   BASH_F_CTRL_ABORT_EN defined: abort_i port present; abort_i=1 in RUN -> next cycle IDLE,
//     cnt_q=0, rc_q=BASH_F_C1, round_vld_o=0, no done_o; abort has priority over round_rdy_i;
//     abort_i outside RUN ignored; abort_i & start_i in IDLE/DONE -> start wins.
//   Not defined: no abort_i port; RUN exits only via last round accept or reset.
// STRUCTURE
//   bash_hash_params_pkg additions: BASH_F_ROUNDS=24; BASH_F_C1=64'hB194BAC80A08F53B
//     (C1 in bash_f_c byte order); typedef enum logic [1:0] {BF_IDLE,BF_RUN,BF_DONE}
//     bash_f_ctrl_state_t. Reuses SLEN, BASH_F_CONST.
//   One sub-module instance: bash_f_c (c_i=rc_q, c_o -> rc_q next value). No others.
// TESTING
//   Reset then start_i 1 cycle, round_rdy_i=1 -> round_idx_o 0..23 on consecutive cycles,
//     rc_o=64'hB194BAC80A08F53B at idx 0, 64'hF692BD1B9C65D1C1 at idx 1, done_o at cycle 25.
//   Full run vs. software model of bash_f_c iterated 23 times -> every rc_o matches, last_o only at idx 23.
//   round_rdy_i random 30% duty -> rc_o/round_idx_o stable while stalled, 24 accepts, single done_o.
//   start_i held high through RUN and in DONE -> RUN ignores it; DONE restarts at idx 0, rc_o=C1.
//   rst_i pulsed at idx 10 -> all outputs at reset values same cycle; no done_o; fresh start OK.
//   BASH_F_CTRL_ABORT_EN: abort_i at idx 5 with round_rdy_i=1 -> IDLE next cycle, idx stays 0, no done_o.

Source files
------------

// File: rtl/bash_hash_params_pkg.sv
// rtl/bash_hash_params_pkg.sv - bash-f shared parameters, round constants and controller state type
package bash_hash_params_pkg;

  // Sponge state lane width; every round constant is one lane
  localparam int SLEN = 64;

  // Rounds per bash-f permutation
  localparam int BASH_F_ROUNDS = 24;

  // Feedback polynomial of the round-constant LFSR (arithmetic word order)
  localparam logic [SLEN-1:0] BASH_F_CONST = 64'hDC2BE1997FE0D8AE;

  // First round constant C1, held in bash_f_c byte order
  localparam logic [SLEN-1:0] BASH_F_C1 = 64'hB194BAC80A08F53B;

  typedef enum logic [1:0] {
    BF_IDLE,
    BF_RUN,
    BF_DONE
  } bash_f_ctrl_state_t;

  // Converts between bash_f_c byte order and arithmetic word order (self-inverse)
  function automatic logic [SLEN-1:0] bash_byte_swap(input logic [SLEN-1:0] x);
    logic [SLEN-1:0] y;
    y = '0;
    for (int b = 0; b < SLEN / 8; b++) begin
      y[8*b +: 8] = x[SLEN - 8 - 8*b +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/bash_f_c.sv
// rtl/bash_f_c.sv - bash-f round constant step C_i -> C_(i+1)
module bash_f_c
  import bash_hash_params_pkg::*;
(
  input  logic [SLEN-1:0] c_i,
  output logic [SLEN-1:0] c_o
);

  logic [SLEN-1:0] word;
  logic [SLEN-1:0] word_next;

  // Galois LFSR step on the arithmetic word: shift right, fold in the polynomial when the LSB was set
  always_comb begin
    word      = bash_byte_swap(c_i);
    word_next = {1'b0, word[SLEN-1:1]} ^ (word[0] ? BASH_F_CONST : '0);
    c_o       = bash_byte_swap(word_next);
  end

endmodule

// File: rtl/bash_f_round_ctrl.sv
// rtl/bash_f_round_ctrl.sv - bash-f round sequencer; optional abort_i via BASH_F_CTRL_ABORT_EN
module bash_f_round_ctrl
  import bash_hash_params_pkg::*;
#(
  parameter  int ROUNDS = BASH_F_ROUNDS,
  localparam int CNT_W  = $clog2(ROUNDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             round_vld_o,
  input  logic             round_rdy_i,
  output logic [CNT_W-1:0] round_idx_o,
  output logic [SLEN-1:0]  rc_o,
  output logic             last_o,
`ifdef BASH_F_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);

  bash_f_ctrl_state_t state_q;
  bash_f_ctrl_state_t state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [SLEN-1:0]  rc_q;
  logic [SLEN-1:0]  rc_step;

  logic start_acc;
  logic round_acc;
  logic cnt_last;
  logic abort_run;

  // Constant generator lives only in the next-value path; rc_o stays a flop output
  bash_f_c u_bash_f_c (
    .c_i (rc_q),
    .c_o (rc_step)
  );

  // Handshake qualifiers shared by the FSM and the counter/constant registers
  always_comb begin
    start_acc = start_i & ((state_q == BF_IDLE) | (state_q == BF_DONE));
    cnt_last  = (cnt_q == CNT_LAST);
`ifdef BASH_F_CTRL_ABORT_EN
    abort_run = abort_i & (state_q == BF_RUN);
`else
    abort_run = 1'b0;
`endif
    // abort outranks a concurrent round accept
    round_acc = (state_q == BF_RUN) & round_rdy_i & ~abort_run;
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE lasts one cycle unless a new start chains straight into RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BF_IDLE: begin
        if (start_acc) state_d = BF_RUN;
      end
      BF_RUN: begin
        if (abort_run)                  state_d = BF_IDLE;
        else if (round_acc && cnt_last) state_d = BF_DONE;
      end
      BF_DONE: begin
        state_d = start_acc ? BF_RUN : BF_IDLE;
      end
      default: state_d = BF_IDLE;
    endcase
  end

  // Round counter and constant: rewound on start/abort/last, stepped on every other accept
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rc_q  <= BASH_F_C1;
    end else if (start_acc || abort_run || (round_acc && cnt_last)) begin
      cnt_q <= '0;
      rc_q  <= BASH_F_C1;
    end else if (round_acc) begin
      cnt_q <= cnt_q + 1'b1;
      rc_q  <= rc_step;
    end
  end

  // Outputs decoded from state; index and constant come straight from their flops
  always_comb begin
    ready_o     = (state_q == BF_IDLE) | (state_q == BF_DONE);
    busy_o      = (state_q == BF_RUN);
    round_vld_o = (state_q == BF_RUN);
    done_o      = (state_q == BF_DONE);
    last_o      = (state_q == BF_RUN) & cnt_last;
    round_idx_o = cnt_q;
    rc_o        = rc_q;
  end

endmodule

// File: tb/tb_bash_f_round_ctrl.sv
// tb/tb_bash_f_round_ctrl.sv - self-checking bench for bash_f_round_ctrl
module tb_bash_f_round_ctrl;

  localparam int R = 24;
  localparam logic [63:0] C1 = 64'hB194BAC80A08F53B;
  localparam logic [63:0] C2 = 64'hF692BD1B9C65D1C1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rdy;
  logic        ready, busy, vld, last, done;
  logic [4:0]  idx;
  logic [63:0] rc;
`ifdef BASH_F_CTRL_ABORT_EN
  logic        abort;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] rc_model [R];

  always #5 clk = ~clk;

  bash_f_round_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .ready_o     (ready),
    .busy_o      (busy),
    .round_vld_o (vld),
    .round_rdy_i (rdy),
    .round_idx_o (idx),
    .rc_o        (rc),
    .last_o      (last),
`ifdef BASH_F_CTRL_ABORT_EN
    .abort_i     (abort),
`endif
    .done_o      (done)
  );

  function automatic logic [63:0] swap64(input logic [63:0] x);
    logic [63:0] y;
    for (int b = 0; b < 8; b++) y[8*b +: 8] = x[8*(7-b) +: 8];
    return y;
  endfunction

  function automatic logic [63:0] lfsr_next(input logic [63:0] v);
    if (v % 2 == 1) return (v / 2) ^ 64'hDC2BE1997FE0D8AE;
    return v / 2;
  endfunction

  task automatic build_model();
    logic [63:0] v;
    v = swap64(C1);
    for (int k = 0; k < R; k++) begin
      rc_model[k] = swap64(v);
      v = lfsr_next(v);
    end
  endtask

  task automatic test_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", vld); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", last); end
    checks++; if (idx !== 5'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    checks++; if (rc !== C1) begin errors++; $display("FAIL reset_rc got=%h exp=%h", rc, C1); end
    rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (vld !== 1'b0 || idx !== 5'd0 || done !== 1'b0)
        begin errors++; $display("FAIL idle_rdy_ignored vld=%b idx=%0d done=%b exp vld=0 idx=0 done=0", vld, idx, done); end
    end
    rdy = 1'b0;
  endtask

  task automatic test_full_rate();
    @(negedge clk); start = 1'b1; rdy = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < R; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (vld !== 1'b1 || idx !== 5'(k) || rc !== rc_model[k] || last !== (k == R-1) || done !== 1'b0)
        begin errors++; $display("FAIL full_round k=%0d vld=%b idx=%0d rc=%h last=%b done=%b exp rc=%h", k, vld, idx, rc, last, done, rc_model[k]); end
      if (k == 0) begin
        checks++; if (rc !== C1) begin errors++; $display("FAIL full_c1 got=%h exp=%h", rc, C1); end
      end
      if (k == 1) begin
        checks++; if (rc !== C2) begin errors++; $display("FAIL full_c2 got=%h exp=%h", rc, C2); end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || vld !== 1'b0)
      begin errors++; $display("FAIL full_done done=%b ready=%b busy=%b vld=%b exp 1 1 0 0", done, ready, busy, vld); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || idx !== 5'd0 || rc !== C1)
      begin errors++; $display("FAIL full_after done=%b idx=%0d rc=%h exp done=0 idx=0 rc=%h", done, idx, rc, C1); end
    rdy = 1'b0;
  endtask

  task automatic test_stall();
    int k;
    int cyc;
    rdy = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0; cyc = 0;
    while (k < R && cyc < 1000) begin
      checks++;
      if (vld !== 1'b1 || idx !== 5'(k) || rc !== rc_model[k] || done !== 1'b0)
        begin errors++; $display("FAIL stall_round k=%0d vld=%b idx=%0d rc=%h done=%b exp rc=%h", k, vld, idx, rc, done, rc_model[k]); end
      rdy = ($urandom_range(0, 99) < 30);
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (k != R) begin errors++; $display("FAIL stall_timeout accepts=%0d exp=%0d", k, R); end
    rdy = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL stall_done got=%b exp=1", done); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || vld !== 1'b0) begin errors++; $display("FAIL stall_single_done done=%b vld=%b exp 0 0", done, vld); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk); start = 1'b1; rdy = 1'b1;
    @(negedge clk);
    for (int k = 0; k < R; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (vld !== 1'b1 || idx !== 5'(k) || rc !== rc_model[k] || ready !== 1'b0)
        begin errors++; $display("FAIL b2b_round k=%0d vld=%b idx=%0d rc=%h ready=%b", k, vld, idx, rc, ready); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL b2b_done done=%b ready=%b exp 1 1", done, ready); end
    @(negedge clk);
    checks++;
    if (vld !== 1'b1 || idx !== 5'd0 || rc !== C1 || done !== 1'b0)
      begin errors++; $display("FAIL b2b_restart vld=%b idx=%0d rc=%h done=%b exp 1 0 %h 0", vld, idx, rc, done, C1); end
    start = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    checks++;
    if (n != R) begin errors++; $display("FAIL b2b_second_run cycles=%0d exp=%0d", n, R); end
    rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk); start = 1'b1; rdy = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (idx !== 5'd10 || rc !== rc_model[10]) begin errors++; $display("FAIL mid_idx10 idx=%0d rc=%h exp 10 %h", idx, rc, rc_model[10]); end
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || vld !== 1'b0 || done !== 1'b0 || last !== 1'b0 || idx !== 5'd0 || rc !== C1)
      begin errors++; $display("FAIL mid_reset ready=%b busy=%b vld=%b done=%b last=%b idx=%0d rc=%h", ready, busy, vld, done, last, idx, rc); end
    @(negedge clk); rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || vld !== 1'b0) begin errors++; $display("FAIL mid_no_done done=%b vld=%b exp 0 0", done, vld); end
    end
    start = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (done === 1'b1) break;
    end
    checks++;
    if (n != R + 1) begin errors++; $display("FAIL mid_fresh_latency cycles=%0d exp=%0d", n, R + 1); end
    rdy = 1'b0;
  endtask

`ifdef BASH_F_CTRL_ABORT_EN
  task automatic test_abort();
    @(negedge clk); start = 1'b1; rdy = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (idx !== 5'd5) begin errors++; $display("FAIL abort_idx5 got=%0d exp=5", idx); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (vld !== 1'b0 || ready !== 1'b1 || idx !== 5'd0 || rc !== C1 || done !== 1'b0)
      begin errors++; $display("FAIL abort_idle vld=%b ready=%b idx=%0d rc=%h done=%b", vld, ready, idx, rc, done); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || idx !== 5'd0) begin errors++; $display("FAIL abort_quiet done=%b idx=%0d exp 0 0", done, idx); end
    end
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    checks++;
    if (vld !== 1'b1 || idx !== 5'd0) begin errors++; $display("FAIL abort_start_wins vld=%b idx=%0d exp 1 0", vld, idx); end
    rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; rdy = 1'b0;
`ifdef BASH_F_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    build_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_full_rate();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef BASH_F_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
